// File: rtl/smiley_move_ctrl.sv
// Smiley sprite motion controller: gathers border hits across a frame, then
// bounces the direction and steps the clamped top-left position once per frame.
module smiley_move_ctrl #(
    parameter int unsigned INIT_X  = 288,
    parameter int unsigned INIT_Y  = 224,
    parameter int unsigned SPEED_X = 2,
    parameter int unsigned SPEED_Y = 1,
    parameter int unsigned X_MAX   = 576,
    parameter int unsigned Y_MAX   = 448
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        collision,
    input  logic [3:0]  HitEdgeCode,
    input  logic        pause,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        mirrorSel,
    output logic [7:0]  bounceCount
);

    localparam int unsigned POS_W  = 11;
    localparam int unsigned CALC_W = 12;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned SUM_W  = CNT_W + 1;
    localparam int unsigned EDGE_W = 4;

    // HitEdgeCode bit positions: {Left, Top, Right, Bottom}
    localparam int unsigned EDGE_LEFT   = 3;
    localparam int unsigned EDGE_TOP    = 2;
    localparam int unsigned EDGE_RIGHT  = 1;
    localparam int unsigned EDGE_BOTTOM = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIR  = 2'd1,
        POS  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              frame_start_c;
    logic              dir_phase_c;
    logic              pos_phase_c;

    logic [EDGE_W-1:0] hit_acc;
    logic [EDGE_W-1:0] frame_hits;
    logic              dir_x;
    logic              dir_y;

    logic              flip_x_c;
    logic              flip_y_c;
    logic [SUM_W-1:0]  bounce_sum_c;
    logic [CNT_W-1:0]  bounce_nxt_c;

    logic signed [CALC_W-1:0] step_x_c;
    logic signed [CALC_W-1:0] step_y_c;
    logic signed [CALC_W-1:0] sum_x_c;
    logic signed [CALC_W-1:0] sum_y_c;
    logic [POS_W-1:0]         pos_x_nxt_c;
    logic [POS_W-1:0]         pos_y_nxt_c;

    // Saturate a signed candidate position into [0, max_v]
    function automatic logic [POS_W-1:0] clamp_axis(
        input logic signed [CALC_W-1:0] val,
        input logic [CALC_W-1:0]        max_v
    );
        logic [POS_W-1:0] res;
        if (val < $signed(CALC_W'(0))) begin
            res = '0;
        end else if (val > $signed(max_v)) begin
            res = POS_W'(max_v);
        end else begin
            res = POS_W'(val);
        end
        return res;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and phase strobes
    always_comb begin
        state_nxt     = state;
        frame_start_c = 1'b0;
        dir_phase_c   = 1'b0;
        pos_phase_c   = 1'b0;
        case (state)
            IDLE: begin
                if (startOfFrame && !pause) begin
                    frame_start_c = 1'b1;
                    state_nxt     = DIR;
                end
            end
            DIR: begin
                dir_phase_c = 1'b1;
                state_nxt   = POS;
            end
            POS: begin
                pos_phase_c = 1'b1;
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Bounce decision: only edges that oppose the current motion flip it
    always_comb begin
        flip_x_c     = (dir_x && frame_hits[EDGE_RIGHT]) || (!dir_x && frame_hits[EDGE_LEFT]);
        flip_y_c     = (dir_y && frame_hits[EDGE_BOTTOM]) || (!dir_y && frame_hits[EDGE_TOP]);
        bounce_sum_c = SUM_W'(bounceCount) + SUM_W'(flip_x_c) + SUM_W'(flip_y_c);
        bounce_nxt_c = (bounce_sum_c > SUM_W'(255)) ? CNT_W'(255) : CNT_W'(bounce_sum_c);
    end

    // Next position from the already-updated direction
    always_comb begin
        step_x_c    = dir_x ? $signed(CALC_W'(SPEED_X)) : -$signed(CALC_W'(SPEED_X));
        step_y_c    = dir_y ? $signed(CALC_W'(SPEED_Y)) : -$signed(CALC_W'(SPEED_Y));
        sum_x_c     = $signed({1'b0, topLeftX}) + step_x_c;
        sum_y_c     = $signed({1'b0, topLeftY}) + step_y_c;
        pos_x_nxt_c = clamp_axis(sum_x_c, CALC_W'(X_MAX));
        pos_y_nxt_c = clamp_axis(sum_y_c, CALC_W'(Y_MAX));
    end

    // Hit accumulation, direction and position registers
    always_ff @(posedge clk) begin
        if (!resetN) begin
            hit_acc     <= '0;
            frame_hits  <= '0;
            dir_x       <= 1'b1;
            dir_y       <= 1'b1;
            mirrorSel   <= 1'b0;
            bounceCount <= '0;
            topLeftX    <= POS_W'(INIT_X);
            topLeftY    <= POS_W'(INIT_Y);
        end else begin
            if (frame_start_c) begin
                // A hit in the frame-start cycle belongs to the next frame
                frame_hits <= hit_acc;
                hit_acc    <= collision ? HitEdgeCode : '0;
            end else if (collision) begin
                hit_acc <= hit_acc | HitEdgeCode;
            end

            if (dir_phase_c) begin
                dir_x       <= dir_x ^ flip_x_c;
                dir_y       <= dir_y ^ flip_y_c;
                mirrorSel   <= ~(dir_x ^ flip_x_c);
                bounceCount <= bounce_nxt_c;
            end

            if (pos_phase_c) begin
                topLeftX <= pos_x_nxt_c;
                topLeftY <= pos_y_nxt_c;
            end
        end
    end

endmodule

// File: tb/tb_smiley_move_ctrl.sv
// Bench for smiley_move_ctrl: directed frame scenarios plus randomized traffic
// against a frame-level reference model; a second instance covers the X clamp.
module tb_smiley_move_ctrl;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic        collision;
    logic [3:0]  HitEdgeCode;
    logic        pause;
    logic [10:0] topLeftX, topLeftY;
    logic        mirrorSel;
    logic [7:0]  bounceCount;
    logic [10:0] x2, y2;
    logic        mir2;
    logic [7:0]  bc2;

    int checks   = 0;
    int failures = 0;

    smiley_move_ctrl dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .collision(collision), .HitEdgeCode(HitEdgeCode), .pause(pause),
        .topLeftX(topLeftX), .topLeftY(topLeftY),
        .mirrorSel(mirrorSel), .bounceCount(bounceCount)
    );

    smiley_move_ctrl #(.INIT_X(575)) dut_edge (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .collision(collision), .HitEdgeCode(HitEdgeCode), .pause(pause),
        .topLeftX(x2), .topLeftY(y2),
        .mirrorSel(mir2), .bounceCount(bc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: frame-level behaviour
    int         m_x, m_y, m_x2, m_bc, m_phase;
    bit         m_dx, m_dy, m_mir;
    logic [3:0] m_acc, m_snap;

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        m_x = 288; m_y = 224; m_x2 = 575; m_bc = 0; m_phase = 0;
        m_dx = 1; m_dy = 1; m_mir = 0; m_acc = 4'b0; m_snap = 4'b0;
    endtask

    // Drive one cycle, advance the model across that edge, settle past it
    task automatic step(input bit rst, input bit sof, input bit col,
                        input logic [3:0] code, input bit pse);
        int fl;
        resetN = rst; startOfFrame = sof; collision = col;
        HitEdgeCode = code; pause = pse;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else if (m_phase == 0 && sof && !pse) begin
            m_snap  = m_acc;
            m_acc   = col ? code : 4'b0;
            m_phase = 1;
        end else begin
            if (col) m_acc = m_acc | code;
            if (m_phase == 1) begin
                fl = 0;
                if ((m_dx && m_snap[1]) || (!m_dx && m_snap[3])) begin m_dx = !m_dx; fl++; end
                if ((m_dy && m_snap[0]) || (!m_dy && m_snap[2])) begin m_dy = !m_dy; fl++; end
                m_mir   = !m_dx;
                m_bc    = (m_bc + fl > 255) ? 255 : m_bc + fl;
                m_phase = 2;
            end else if (m_phase == 2) begin
                m_x     = clampi(m_x + (m_dx ? 2 : -2), 576);
                m_x2    = clampi(m_x2 + (m_dx ? 2 : -2), 576);
                m_y     = clampi(m_y + (m_dy ? 1 : -1), 448);
                m_phase = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        step(0, 0, 0, 4'b0, 0);
        step(0, 0, 0, 4'b0, 0);
    endtask

    task automatic run_frame();
        step(1, 1, 0, 4'b0, 0);
        step(1, 0, 0, 4'b0, 0);
        step(1, 0, 0, 4'b0, 0);
    endtask

    task automatic test_reset();
        // Inputs must be ignored while reset is held
        step(0, 1, 1, 4'b1111, 0);
        step(0, 1, 1, 4'b1111, 0);
        checks++; if (topLeftX !== 11'd288) begin failures++; $display("FAIL reset_x got %0d exp 288", topLeftX); end
        checks++; if (topLeftY !== 11'd224) begin failures++; $display("FAIL reset_y got %0d exp 224", topLeftY); end
        checks++; if (mirrorSel !== 1'b0) begin failures++; $display("FAIL reset_mirror got %0b exp 0", mirrorSel); end
        checks++; if (bounceCount !== 8'd0) begin failures++; $display("FAIL reset_bounce got %0d exp 0", bounceCount); end
        checks++; if (x2 !== 11'd575) begin failures++; $display("FAIL reset_x2 got %0d exp 575", x2); end
    endtask

    task automatic test_basic_frame();
        step(1, 1, 0, 4'b0, 0);
        step(1, 0, 0, 4'b0, 0);
        checks++; if (topLeftX !== 11'd288) begin failures++; $display("FAIL basic_latency_x got %0d exp 288", topLeftX); end
        step(1, 0, 0, 4'b0, 0);
        checks++; if (topLeftX !== 11'd290) begin failures++; $display("FAIL basic_x got %0d exp 290", topLeftX); end
        checks++; if (topLeftY !== 11'd225) begin failures++; $display("FAIL basic_y got %0d exp 225", topLeftY); end
        checks++; if (mirrorSel !== 1'b0) begin failures++; $display("FAIL basic_mirror got %0b exp 0", mirrorSel); end
        checks++; if (bounceCount !== 8'd0) begin failures++; $display("FAIL basic_bounce got %0d exp 0", bounceCount); end
        // Outputs hold through idle cycles
        step(1, 0, 0, 4'b0, 0);
        step(1, 0, 0, 4'b0, 0);
        checks++; if (topLeftX !== 11'd290) begin failures++; $display("FAIL idle_hold_x got %0d exp 290", topLeftX); end
    endtask

    task automatic test_right_hit();
        step(1, 0, 1, 4'b0010, 0);
        step(1, 1, 0, 4'b0, 0);
        step(1, 0, 0, 4'b0, 0);
        checks++; if (mirrorSel !== 1'b1) begin failures++; $display("FAIL right_mirror got %0b exp 1", mirrorSel); end
        checks++; if (topLeftX !== 11'd290) begin failures++; $display("FAIL right_early_x got %0d exp 290", topLeftX); end
        step(1, 0, 0, 4'b0, 0);
        checks++; if (topLeftX !== 11'd288) begin failures++; $display("FAIL right_x got %0d exp 288", topLeftX); end
        checks++; if (topLeftY !== 11'd226) begin failures++; $display("FAIL right_y got %0d exp 226", topLeftY); end
        checks++; if (bounceCount !== 8'd1) begin failures++; $display("FAIL right_bounce got %0d exp 1", bounceCount); end
    endtask

    task automatic test_non_opposing();
        do_reset();
        step(1, 0, 1, 4'b1000, 0);
        run_frame();
        checks++; if (topLeftX !== 11'd290) begin failures++; $display("FAIL nonopp_x got %0d exp 290", topLeftX); end
        checks++; if (bounceCount !== 8'd0) begin failures++; $display("FAIL nonopp_bounce got %0d exp 0", bounceCount); end
        checks++; if (mirrorSel !== 1'b0) begin failures++; $display("FAIL nonopp_mirror got %0b exp 0", mirrorSel); end
    endtask

    task automatic test_double_flip();
        do_reset();
        step(1, 0, 1, 4'b0011, 0);
        run_frame();
        checks++; if (topLeftX !== 11'd286) begin failures++; $display("FAIL double_x got %0d exp 286", topLeftX); end
        checks++; if (topLeftY !== 11'd223) begin failures++; $display("FAIL double_y got %0d exp 223", topLeftY); end
        checks++; if (mirrorSel !== 1'b1) begin failures++; $display("FAIL double_mirror got %0b exp 1", mirrorSel); end
        checks++; if (bounceCount !== 8'd2) begin failures++; $display("FAIL double_bounce got %0d exp 2", bounceCount); end
    endtask

    task automatic test_clamp();
        do_reset();
        run_frame();
        checks++; if (x2 !== 11'd576) begin failures++; $display("FAIL clamp_x2 got %0d exp 576", x2); end
        checks++; if (mir2 !== 1'b0) begin failures++; $display("FAIL clamp_mirror got %0b exp 0", mir2); end
        run_frame();
        checks++; if (x2 !== 11'd576) begin failures++; $display("FAIL clamp_hold_x2 got %0d exp 576", x2); end
    endtask

    task automatic test_coincident();
        do_reset();
        step(1, 1, 1, 4'b0010, 0);
        step(1, 0, 0, 4'b0, 0);
        step(1, 0, 0, 4'b0, 0);
        checks++; if (topLeftX !== 11'd290) begin failures++; $display("FAIL coinc_first_x got %0d exp 290", topLeftX); end
        checks++; if (mirrorSel !== 1'b0) begin failures++; $display("FAIL coinc_first_mirror got %0b exp 0", mirrorSel); end
        run_frame();
        checks++; if (topLeftX !== 11'd288) begin failures++; $display("FAIL coinc_second_x got %0d exp 288", topLeftX); end
        checks++; if (bounceCount !== 8'd1) begin failures++; $display("FAIL coinc_bounce got %0d exp 1", bounceCount); end
    endtask

    task automatic test_pause();
        do_reset();
        step(1, 0, 1, 4'b0010, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 4'b0, 1);
        checks++; if (topLeftX !== 11'd288) begin failures++; $display("FAIL pause_x got %0d exp 288", topLeftX); end
        checks++; if (mirrorSel !== 1'b0) begin failures++; $display("FAIL pause_mirror got %0b exp 0", mirrorSel); end
        // Hit gathered before the paused frames is still applied
        run_frame();
        checks++; if (topLeftX !== 11'd286) begin failures++; $display("FAIL pause_retain_x got %0d exp 286", topLeftX); end
        checks++; if (bounceCount !== 8'd1) begin failures++; $display("FAIL pause_retain_bounce got %0d exp 1", bounceCount); end
    endtask

    task automatic test_reset_in_dir();
        do_reset();
        step(1, 0, 1, 4'b0011, 0);
        step(1, 1, 0, 4'b0, 0);
        step(0, 0, 0, 4'b0, 0);
        checks++; if (topLeftX !== 11'd288) begin failures++; $display("FAIL rstdir_x got %0d exp 288", topLeftX); end
        checks++; if (topLeftY !== 11'd224) begin failures++; $display("FAIL rstdir_y got %0d exp 224", topLeftY); end
        checks++; if (mirrorSel !== 1'b0) begin failures++; $display("FAIL rstdir_mirror got %0b exp 0", mirrorSel); end
        checks++; if (bounceCount !== 8'd0) begin failures++; $display("FAIL rstdir_bounce got %0d exp 0", bounceCount); end
        step(1, 0, 0, 4'b0, 0);
        checks++; if (topLeftX !== 11'd288) begin failures++; $display("FAIL rstdir_idle_x got %0d exp 288", topLeftX); end
        run_frame();
        checks++; if (topLeftX !== 11'd290) begin failures++; $display("FAIL rstdir_next_x got %0d exp 290", topLeftX); end
        checks++; if (topLeftY !== 11'd225) begin failures++; $display("FAIL rstdir_next_y got %0d exp 225", topLeftY); end
        checks++; if (bounceCount !== 8'd0) begin failures++; $display("FAIL rstdir_next_bounce got %0d exp 0", bounceCount); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int f = 0; f < 140; f++) begin
            step(1, 1, 1, 4'b1111, 0);
            step(1, 0, 0, 4'b0, 0);
            step(1, 0, 0, 4'b0, 0);
        end
        checks++; if (bounceCount !== 8'd255) begin failures++; $display("FAIL sat_bounce got %0d exp 255", bounceCount); end
        checks++; if (int'(topLeftX) !== m_x) begin failures++; $display("FAIL sat_x got %0d exp %0d", topLeftX, m_x); end
        checks++; if (int'(topLeftY) !== m_y) begin failures++; $display("FAIL sat_y got %0d exp %0d", topLeftY, m_y); end
    endtask

    task automatic test_random();
        bit rst, sof, col, pse;
        logic [3:0] code;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 59) != 0);
            sof  = ($urandom_range(0, 2) == 0);
            col  = ($urandom_range(0, 1) == 0);
            pse  = ($urandom_range(0, 3) == 0);
            code = 4'($urandom_range(0, 15));
            step(rst, sof, col, code, pse);
            checks++; if (int'(topLeftX) !== m_x) begin failures++; $display("FAIL rand_x cyc %0d got %0d exp %0d", i, topLeftX, m_x); end
            checks++; if (int'(topLeftY) !== m_y) begin failures++; $display("FAIL rand_y cyc %0d got %0d exp %0d", i, topLeftY, m_y); end
            checks++; if (mirrorSel !== m_mir) begin failures++; $display("FAIL rand_mirror cyc %0d got %0b exp %0b", i, mirrorSel, m_mir); end
            checks++; if (int'(bounceCount) !== m_bc) begin failures++; $display("FAIL rand_bounce cyc %0d got %0d exp %0d", i, bounceCount, m_bc); end
            checks++; if (int'(x2) !== m_x2) begin failures++; $display("FAIL rand_x2 cyc %0d got %0d exp %0d", i, x2, m_x2); end
        end
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; collision = 1'b0;
        HitEdgeCode = 4'b0; pause = 1'b0;
        model_reset();
        test_reset();
        test_basic_frame();
        test_right_hit();
        test_non_opposing();
        test_double_flip();
        test_clamp();
        test_coincident();
        test_pause();
        test_reset_in_dir();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
